// File: rtl/spi_slave_shifter_if.sv
// rtl/spi_slave_shifter_if.sv - Signal bundle between SPI slave shifter and its host logic
// Purpose: groups the serial-side strobes, the transmit/receive word handshakes
//          and the status bits of spi_slave_shifter.
// Signals:
//   cs_n, mosi, lead_edge, trail_edge : synchronised SPI inputs and SCLK edge strobes
//   miso                              : serial transmit bit
//   tx_data, tx_valid, tx_ready       : transmit holding register write handshake
//   rx_data, rx_valid, rx_ready       : received word handshake
//   busy, rx_overrun, tx_underrun     : frame activity and sticky error flags
//   status_clr                        : clears the sticky error flags
// Modports: slave = shifter side, master = host/driver side.
interface spi_slave_shifter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs_n;
  logic                  mosi;
  logic                  lead_edge;
  logic                  trail_edge;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  rx_overrun;
  logic                  tx_underrun;
  logic                  status_clr;

  modport slave (
    input  cs_n, mosi, lead_edge, trail_edge, tx_data, tx_valid, rx_ready, status_clr,
    output miso, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );

  modport master (
    output cs_n, mosi, lead_edge, trail_edge, tx_data, tx_valid, rx_ready, status_clr,
    input  miso, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI slave bit engine: MOSI deserialiser and MISO serialiser
// Purpose: consumes single-cycle leading/trailing SCLK strobes (CPOL already
//          normalised) plus synchronised cs_n/mosi; assembles MOSI words with a
//          valid/ready output and shifts a buffered transmit word onto MISO.
//          Words run back-to-back inside one cs_n frame.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   bus  : spi_slave_shifter_if.slave (cs_n, mosi, lead_edge, trail_edge, miso,
//          tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready, busy,
//          rx_overrun, tx_underrun, status_clr)
// Parameters: DATA_WIDTH (2..32), CPHA (0/1), MSB_FIRST (1 = MSB first on both lines)
// Optional: define SPI_SHIFTER_STATUS_EN to implement the sticky rx_overrun and
//           tx_underrun flags; otherwise both read 0 and status_clr is ignored.
module spi_slave_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input logic                clk,
  input logic                rst,
  spi_slave_shifter_if.slave bus
);
  localparam int            CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, hold_q, rx_data_q;
  logic                  hold_full_q, rx_valid_q;

  logic                  busy, abort, load_en, shift_en, sample_en;
  logic                  lead_only, trail_only, word_done, tx_hs;
  logic                  overrun_evt, underrun_evt;
  logic [DATA_WIDTH-1:0] rx_shift_d, tx_shift_d;

  // Coincident strobes are a protocol violation and are dropped entirely.
  assign lead_only  = bus.lead_edge & ~bus.trail_edge;
  assign trail_only = bus.trail_edge & ~bus.lead_edge;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.cs_n) state_d = S_ACTIVE;
      S_ACTIVE: if (bus.cs_n)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    abort     = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      // CPHA=0 must present the first bit before the first leading edge,
      // so the word is loaded as soon as cs_n falls.
      S_IDLE: load_en = (CPHA == 0) && !bus.cs_n;
      S_ACTIVE: begin
        busy = 1'b1;
        if (bus.cs_n) begin
          abort = 1'b1;
        end else if (CPHA == 0) begin
          // Count parks at DATA_WIDTH until the trailing edge reloads MISO.
          sample_en = lead_only && (bit_cnt_q != CNT_FULL);
          load_en   = trail_only && (bit_cnt_q == CNT_FULL);
          shift_en  = trail_only && (bit_cnt_q != CNT_FULL);
        end else begin
          load_en   = lead_only && (bit_cnt_q == '0);
          shift_en  = lead_only && (bit_cnt_q != '0);
          sample_en = trail_only;
        end
      end
      default: ;
    endcase
  end

  assign word_done    = sample_en && (bit_cnt_q == CNT_LAST);
  assign tx_hs        = bus.tx_valid && !hold_full_q;
  assign underrun_evt = load_en && !hold_full_q;
  assign overrun_evt  = word_done && rx_valid_q && !bus.rx_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.mosi};
      assign tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      assign bus.miso   = tx_shift_q[DATA_WIDTH-1];
    end else begin : g_lsb
      assign rx_shift_d = {bus.mosi, rx_shift_q[DATA_WIDTH-1:1]};
      assign tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
      assign bus.miso   = tx_shift_q[0];
    end
  endgenerate

  // Shift registers are cleared on frame end, which also forces miso low in IDLE.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
    end else begin
      if (sample_en) begin
        rx_shift_q <= rx_shift_d;
        bit_cnt_q  <= (CPHA != 0 && word_done) ? '0 : bit_cnt_q + CW'(1);
      end else if (load_en && CPHA == 0) begin
        bit_cnt_q <= '0;
      end
      if (load_en)       tx_shift_q <= hold_full_q ? hold_q : '0;
      else if (shift_en) tx_shift_q <= tx_shift_d;
    end
  end

  // A write coinciding with a load on an empty holding register lands in the
  // holding register for the following word; there is no bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (tx_hs) begin
      hold_q      <= bus.tx_data;
      hold_full_q <= 1'b1;
    end else if (load_en) begin
      hold_full_q <= 1'b0;
    end
  end

  // A completed word replaces rx_data only if the old one is gone or is being
  // accepted in this very cycle; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (word_done && (!rx_valid_q || bus.rx_ready)) begin
      rx_data_q  <= rx_shift_d;
      rx_valid_q <= 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.tx_ready = !hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy;

`ifdef SPI_SHIFTER_STATUS_EN
  logic rx_overrun_q, tx_underrun_q;

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      if (overrun_evt)         rx_overrun_q <= 1'b1;
      else if (bus.status_clr) rx_overrun_q <= 1'b0;
      if (underrun_evt)        tx_underrun_q <= 1'b1;
      else if (bus.status_clr) tx_underrun_q <= 1'b0;
    end
  end

  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;
`else
  logic unused_status;
  assign unused_status   = bus.status_clr ^ overrun_evt ^ underrun_evt;
  assign bus.rx_overrun  = 1'b0;
  assign bus.tx_underrun = 1'b0;
`endif
endmodule
